// File: rtl/frame_tick_pkg.sv
// frame_tick_pkg: shared constants and types for the frame tick generator.
//   FPS15/FPS10/FPS1 : tick periods in 50 MHz clock cycles for common frame rates
//   DEFAULT_PERIOD   : period every channel starts with out of reset (~60 Hz)
//   chan_idx_t       : channel index wide enough for the largest supported block
package frame_tick_pkg;

  localparam int unsigned FPS15          = 3333333;
  localparam int unsigned FPS10          = 5000000;
  localparam int unsigned FPS1           = 50000000;
  localparam int unsigned DEFAULT_PERIOD = 833333;

  localparam int unsigned MAX_CHANNELS = 16;
  localparam int unsigned CHAN_IDX_W   = $clog2(MAX_CHANNELS);

  typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable down-counter emitting a one-cycle tick every
// `period` stepping cycles, periodic or one-shot.
//   clk, reset     : clock, synchronous active-high reset
//   count_en       : global and per-channel enable already combined
//   sync           : reload the counter from the period (active channels only)
//   wr_en          : accepted config write targeting this channel
//   wr_period      : new period N
//   wr_oneshot     : new mode, 1 = one-shot
//   wr_immediate   : load the counter now instead of at the next reload
//   tick           : registered one-cycle pulse
//   busy           : registered copy of the active flag
module tick_channel #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = frame_tick_pkg::DEFAULT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_period,
  input  logic             wr_oneshot,
  input  logic             wr_immediate,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] RST_CNT    =
    (DEFAULT_PERIOD == 0) ? '0 : WIDTH'(DEFAULT_PERIOD - 1);
  localparam logic             RST_ACTIVE = (DEFAULT_PERIOD != 0);

  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             oneshot_q, oneshot_d;
  logic             active_q, active_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             step;
  logic             reload;

  // Next-state: sync beats stepping; a config write is layered on top.
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    oneshot_d = oneshot_q;
    active_d  = active_q;
    tick_d    = 1'b0;
    busy_d    = active_q && (period_q != '0);
    step      = count_en && active_q;
    reload    = step && (cnt_q == '0) && !sync;

    if (sync) begin
      if (active_q) cnt_d = period_q - WIDTH'(1);
    end else if (step) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        // A finished one-shot parks with cnt at 0.
        if (oneshot_q) active_d = 1'b0;
        else           cnt_d    = period_q - WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end

    if (wr_en) begin
      period_d  = wr_period;
      oneshot_d = wr_oneshot;
      if (wr_period == '0) begin
        active_d = 1'b0;
        cnt_d    = '0;
        tick_d   = 1'b0;
      end else if (wr_immediate || wr_oneshot || sync) begin
        active_d = 1'b1;
        cnt_d    = wr_period - WIDTH'(1);
        tick_d   = 1'b0;
      end else begin
        // Deferred: only a reload landing this cycle sees the new period.
        active_d = 1'b1;
        if (reload) cnt_d = wr_period - WIDTH'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q  <= RST_PERIOD;
      cnt_q     <= RST_CNT;
      oneshot_q <= 1'b0;
      active_q  <= RST_ACTIVE;
      tick_q    <= 1'b0;
      busy_q    <= RST_ACTIVE;
    end else begin
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      oneshot_q <= oneshot_d;
      active_q  <= active_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: multi-channel frame tick generator with a valid/ready
// config port.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : global count enable
//   ch_enable     : per-channel count enable (pause)
//   sync_all      : restart all active channels phase-aligned
//   cfg_valid/cfg_ready : config handshake (ready is low only during reset)
//   cfg_chan, cfg_period, cfg_oneshot, cfg_immediate : config payload
//   tick          : one-cycle pulse per channel
//   busy          : channel armed with a non-zero period
module frame_tick_gen #(
  parameter  int unsigned CHANNELS       = 4,
  parameter  int unsigned WIDTH          = 32,
  parameter  int unsigned DEFAULT_PERIOD = frame_tick_pkg::DEFAULT_PERIOD,
  localparam int unsigned CHAN_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic                sync_all,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic                cfg_immediate,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  import frame_tick_pkg::*;

  logic      cfg_ready_q, cfg_ready_d;
  logic      cfg_accept;
  chan_idx_t cfg_sel;

  // Config decode; out-of-range channel indices match no channel.
  always_comb begin
    cfg_ready_d = 1'b1;
    cfg_accept  = cfg_valid && cfg_ready_q;
    cfg_sel     = chan_idx_t'(cfg_chan);
  end

  always_ff @(posedge clk) begin
    if (reset) cfg_ready_q <= 1'b0;
    else       cfg_ready_q <= cfg_ready_d;
  end

  assign cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tick_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .count_en     (enable && ch_enable[i]),
      .sync         (sync_all),
      .wr_en        (cfg_accept && (cfg_sel == chan_idx_t'(i))),
      .wr_period    (cfg_period),
      .wr_oneshot   (cfg_oneshot),
      .wr_immediate (cfg_immediate),
      .tick         (tick[i]),
      .busy         (busy[i])
    );
  end

endmodule
